// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch stage with a small prefetch buffer, sitting between the
// instruction memory and the IF/ID pipeline register.  It walks a sequential
// fetch address, captures each returned instruction together with its PC+4,
// and queues them so that a decode stall does not stop fetching until the
// buffer is full.  A redirect (taken branch or jump) flushes the queue and
// restarts fetching at the target address.
//
// Parameters
//   DEPTH       queue entries, power of 2 and at least 2
//   RESET_PC    fetch address after reset
//
// Ports
//   Clk         clock, all state changes on the rising edge
//   Rst         synchronous active-low reset
//   Stall       decode cannot accept an instruction this cycle
//   Redirect    flush the queue and refetch from RedirectPC
//   RedirectPC  word-aligned branch/jump target
//   ImemAddr    fetch address to instruction memory
//   ImemData    instruction word at ImemAddr (combinational read)
//   OutValid    head entry is valid
//   OutInstr    head instruction, zero (NOP) when the queue is empty
//   OutPCPlus4  head PC+4, zero when the queue is empty
//   Count       number of occupied entries
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic                         Stall,
   input  logic                         Redirect,
   input  logic [31:0]                  RedirectPC,
   output logic [31:0]                  ImemAddr,
   input  logic [31:0]                  ImemData,
   output logic                         OutValid,
   output logic [31:0]                  OutInstr,
   output logic [31:0]                  OutPCPlus4,
   output logic [$clog2(DEPTH+1)-1:0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   buf_instr_q [DEPTH];
   logic [31:0]   buf_instr_d [DEPTH];
   logic [31:0]   buf_pc4_q   [DEPTH];
   logic [31:0]   buf_pc4_d   [DEPTH];

   logic          head_valid;
   logic          pop;
   logic          push;
   logic [31:0]   pc_plus4;

   // Full/empty come only from the occupancy count, so the pointers can be
   // bare log2(DEPTH)-bit values that wrap on their own.
   assign head_valid = (count_q != '0);
   assign pop        = head_valid & ~Stall;
   // A full queue can still accept a new word when the head leaves in the
   // same cycle.
   assign push       = (count_q < DEPTH_C) | pop;
   assign pc_plus4   = fetch_pc_q + 32'd4;

   // Next-state logic.  Redirect wins over push and pop: the word returned
   // for the old stream is dropped, and a head popped in the same cycle is
   // treated as already consumed by decode.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;

      if (Redirect) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = RedirectPC;
      end else begin
         if (push) begin
            buf_instr_d[wr_ptr_q] = ImemData;
            buf_pc4_d[wr_ptr_q]   = pc_plus4;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            fetch_pc_d            = pc_plus4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset, which overrides
   // redirect, stall and push alike.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_instr_q[i] <= '0;
            buf_pc4_q[i]   <= '0;
         end
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
      end
   end

   // Outputs come purely from registered state, so there is no path from
   // ImemData to the head outputs.
   assign ImemAddr   = fetch_pc_q;
   assign OutValid   = head_valid;
   assign OutInstr   = head_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
   assign OutPCPlus4 = head_valid ? buf_pc4_q[rd_ptr_q]   : 32'h0;
   assign Count      = count_q;

endmodule
